uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 CLK  input  1  clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 RX_IN  input  1  serial line, idle high; already synchronised to CLK upstream.
REQ-005 PRESCALE  input  6  CLK cycles per bit; legal values 8, 16, 32.
REQ-006 PAR_EN  input  1  1 = parity bit present after data.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 P_DATA  output  DATA_WIDTH  last good received word, LSB = first data bit.
REQ-009 DATA_VALID  output  1  one-cycle pulse, P_DATA updated this cycle.
REQ-010 PAR_ERR  output  1  one-cycle pulse, parity mismatch in the frame just ended.
REQ-011 STP_ERR  output  1  one-cycle pulse, stop bit sampled low in the frame just ended.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-013 Frame: start (0), DATA_WIDTH data bits LSB first, optional parity, one stop (1); each bit is PRESCALE cycles long.
REQ-014 In IDLE, a cycle with RX_IN=0 SHALL move to START; that cycle is edge count 0 of the start bit.
REQ-015 PRESCALE, PAR_EN, PAR_TYP SHALL be latched in the start-detect cycle and held for the whole frame; mid-frame input changes are ignored.
REQ-016 An edge counter SHALL run 0..PRESCALE-1 within each bit and wrap to 0; a bit counter SHALL count data bits 0..DATA_WIDTH-1.
REQ-017 Each bit value SHALL be the majority of RX_IN sampled at edge counts PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1.
REQ-018 START: at edge count PRESCALE-1, if the voted start bit is 1 (glitch), go to IDLE with no output pulse; otherwise go to DATA.
REQ-019 DATA: shift each voted bit into a shift register LSB first; after bit DATA_WIDTH-1 ends, go to PARITY if PAR_EN, else to STOP.
REQ-020 PARITY: expected bit = XOR of data bits (even) or its inverse (odd); record mismatch; go to STOP at edge count PRESCALE-1.
REQ-021 STOP: at edge count PRESCALE-1, go to IDLE and evaluate the frame.
REQ-022 Frame evaluation, registered, effective the cycle after the last stop-bit edge count: no errors -> DATA_VALID=1 and P_DATA=shift register; parity mismatch -> PAR_ERR=1; stop bit 0 -> STP_ERR=1; both errors may pulse together.
REQ-023 On any error DATA_VALID SHALL stay 0 and P_DATA SHALL hold its previous value.
REQ-024 DATA_VALID, PAR_ERR, STP_ERR SHALL be high for exactly one cycle per frame.
REQ-025 Latency: start-detect cycle = cycle 0; outputs pulse in cycle PRESCALE*(2+DATA_WIDTH+PAR_EN).
REQ-026 Back-to-back: a start bit beginning in the cycle the FSM returns to IDLE SHALL be detected one cycle late; the frame SHALL still be received correctly.
REQ-027 Illegal PRESCALE values give undefined data but SHALL NOT lock the FSM out of IDLE.

Reset
REQ-028 RST high SHALL immediately force IDLE, zero all counters and the shift register, and set P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0.
REQ-029 Reset mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL restart only on a new RX_IN low in IDLE.

Verification
REQ-030 PRESCALE=8, PAR_EN=0, send 0xA5 -> DATA_VALID for one cycle at cycle 80, P_DATA=0xA5, no error pulses.
REQ-031 PRESCALE=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> DATA_VALID at cycle 176, P_DATA=0x3C; same frame with parity 1 -> PAR_ERR pulse, DATA_VALID=0, P_DATA unchanged.
REQ-032 PRESCALE=8, send 0x5A with stop bit 0 -> STP_ERR pulse, DATA_VALID=0; next correct frame 0x11 -> DATA_VALID, P_DATA=0x11.
REQ-033 PRESCALE=8, RX_IN low for 2 cycles then high -> FSM returns to IDLE after the start bit, no pulse on any output.
REQ-034 Assert RST during data bit 4 of a frame -> all outputs 0 immediately, no DATA_VALID; next frame 0xC3 received correctly.
REQ-035 PRESCALE=32, two back-to-back frames 0x01 then 0xFE with no idle gap -> two DATA_VALID pulses with matching P_DATA.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: majority-voted bit sampling, optional parity,
// registered one-cycle frame result pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_n;

  logic [5:0]            ecnt;
  logic [5:0]            ps;
  logic [5:0]            half;
  logic [BW-1:0]         bcnt;
  logic                  pen;
  logic                  ptyp;
  logic                  perr_q;
  logic [2:0]            samp;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  bit_end;
  logic                  last_bit;
  logic                  sample_now;
  logic                  vote;

  assign half       = {1'b0, ps[5:1]};
  assign bit_end    = (ecnt == ps - 6'd1);
  assign last_bit   = (bcnt == BW'(DATA_WIDTH - 1));
  assign sample_now = (ecnt == half - 6'd1) ||
                      (ecnt == half) ||
                      (ecnt == half + 6'd1);
  assign vote       = (samp[0] & samp[1]) |
                      (samp[1] & samp[2]) |
                      (samp[0] & samp[2]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (!RX_IN) state_n = START;
      START:  if (bit_end) state_n = vote ? IDLE : DATA;
      DATA:   if (bit_end && last_bit)
                state_n = pen ? PARITY : STOP;
      PARITY: if (bit_end) state_n = STOP;
      STOP:   if (bit_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ecnt       <= '0;
      bcnt       <= '0;
      ps         <= '0;
      pen        <= 1'b0;
      ptyp       <= 1'b0;
      perr_q     <= 1'b0;
      samp       <= '0;
      shreg      <= '0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (state == IDLE) begin
        ecnt <= '0;
        bcnt <= '0;
        // start-detect cycle counts as edge 0 of the start bit
        if (!RX_IN) begin
          ps     <= PRESCALE;
          pen    <= PAR_EN;
          ptyp   <= PAR_TYP;
          perr_q <= 1'b0;
          ecnt   <= 6'd1;
        end
      end else begin
        ecnt <= bit_end ? 6'd0 : ecnt + 6'd1;
        if (sample_now) samp <= {samp[1:0], RX_IN};
      end
      if (state == DATA && bit_end) begin
        shreg <= {vote, shreg[DATA_WIDTH-1:1]};
        bcnt  <= last_bit ? '0 : bcnt + BW'(1);
      end
      if (state == PARITY && bit_end)
        perr_q <= vote ^ (^shreg) ^ ptyp;
      if (state == STOP && bit_end) begin
        PAR_ERR <= perr_q;
        STP_ERR <= !vote;
        if (!perr_q && vote) begin
          DATA_VALID <= 1'b1;
          P_DATA     <= shreg;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: latency, parity, stop, glitch,
// reset abort and back-to-back frames.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int checks;
  int errors;
  int dv_cnt;
  int pe_cnt;
  int se_cnt;
  int exp_dv;
  int exp_pe;
  int exp_se;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK        (clk),
    .RST        (rst),
    .RX_IN      (rx),
    .PRESCALE   (prescale),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_ERR    (par_err),
    .STP_ERR    (stp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (data_valid) dv_cnt <= dv_cnt + 1;
    if (par_err)    pe_cnt <= pe_cnt + 1;
    if (stp_err)    se_cnt <= se_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one full frame from a negedge; returns at the negedge of
  // the cycle in which the result pulse is expected.
  task automatic send(input logic [7:0] d,
                      input int p,
                      input logic pe,
                      input logic pbit,
                      input logic stopb);
    logic typ;
    typ      = par_typ;
    prescale = 6'(p);
    par_en   = pe;
    rx       = 1'b0;
    repeat (p) @(negedge clk);
    prescale = 6'd13;
    par_en   = ~pe;
    par_typ  = ~typ;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (p) @(negedge clk);
    end
    if (pe) begin
      rx = pbit;
      repeat (p) @(negedge clk);
    end
    rx = stopb;
    repeat (p - 1) @(negedge clk);
    chk("no_early_pulse",
        {29'd0, data_valid, par_err, stp_err}, 32'd0);
    @(negedge clk);
    rx       = 1'b1;
    prescale = 6'(p);
    par_en   = pe;
    par_typ  = typ;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_dv"}, dv_cnt, exp_dv);
    chk({tag, "_pe"}, pe_cnt, exp_pe);
    chk({tag, "_se"}, se_cnt, exp_se);
  endtask

  initial begin
    logic got;
    checks   = 0;
    errors   = 0;
    dv_cnt   = 0;
    pe_cnt   = 0;
    se_cnt   = 0;
    exp_dv   = 0;
    exp_pe   = 0;
    exp_se   = 0;
    rst      = 1'b1;
    rx       = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pdata", p_data, 32'h00);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_pe", par_err, 1'b0);
    chk("rst_se", stp_err, 1'b0);
    rst = 1'b0;
    idle(4);

    // 0xA5, P=8, no parity: pulse at cycle 80
    send(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    chk("a5_dv", data_valid, 1'b1);
    chk("a5_data", p_data, 32'hA5);
    chk("a5_errs", {par_err, stp_err}, 2'b00);
    exp_dv++;
    @(negedge clk);
    chk("a5_dv_drop", data_valid, 1'b0);
    idle(3);
    chk_counts("a5");

    // 0x3C, P=16, even parity bit 0: pulse at cycle 176
    par_typ = 1'b0;
    send(8'h3C, 16, 1'b1, 1'b0, 1'b1);
    chk("3c_dv", data_valid, 1'b1);
    chk("3c_data", p_data, 32'h3C);
    exp_dv++;
    idle(3);
    send(8'h3C, 16, 1'b1, 1'b1, 1'b1);
    chk("3c_bad_pe", par_err, 1'b1);
    chk("3c_bad_dv", data_valid, 1'b0);
    chk("3c_bad_data", p_data, 32'h3C);
    exp_pe++;
    idle(3);
    chk_counts("par");

    // 0x5A with stop bit low, then 0x11
    send(8'h5A, 8, 1'b0, 1'b0, 1'b0);
    chk("5a_se", stp_err, 1'b1);
    chk("5a_pe", par_err, 1'b0);
    chk("5a_dv", data_valid, 1'b0);
    chk("5a_data", p_data, 32'h3C);
    exp_se++;
    idle(3);
    send(8'h11, 8, 1'b0, 1'b0, 1'b1);
    chk("11_dv", data_valid, 1'b1);
    chk("11_data", p_data, 32'h11);
    exp_dv++;
    idle(3);
    chk_counts("stp");

    // start glitch: two low cycles only
    prescale = 6'd8;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(30);
    chk_counts("glitch");
    chk("glitch_data", p_data, 32'h11);

    // reset during data bit 4 of 0xAA
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0] ? 1'b1 : 1'b0;
      repeat (8) @(negedge clk);
    end
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    chk("mid_rst_data", p_data, 32'h00);
    chk("mid_rst_flags",
        {data_valid, par_err, stp_err}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    idle(40);
    chk_counts("mid_rst");
    send(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    chk("c3_dv", data_valid, 1'b1);
    chk("c3_data", p_data, 32'hC3);
    exp_dv++;
    idle(3);

    // P=32 back-to-back 0x01 then 0xFE
    send(8'h01, 32, 1'b0, 1'b0, 1'b1);
    chk("b2b1_dv", data_valid, 1'b1);
    chk("b2b1_data", p_data, 32'h01);
    exp_dv++;
    send(8'hFE, 32, 1'b0, 1'b0, 1'b1);
    got = data_valid;
    if (!got) begin
      @(negedge clk);
      got = data_valid;
    end
    chk("b2b2_dv", got, 1'b1);
    chk("b2b2_data", p_data, 32'hFE);
    exp_dv++;
    idle(5);
    chk_counts("final");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
